// File: rtl/mem_stage.sv
// Memory-access stage: word-addressed data RAM with configurable wait states,
// upstream stall generation, and the MEM->WB pipeline register.
module mem_stage #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic [31:0] ALUResIn,
  input  logic [31:0] STValIn,
  input  logic [4:0]  destIn,
  output logic        freeze,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic [31:0] ALURes,
  output logic [31:0] memRead,
  output logic [4:0]  dest,
  output logic        addrErr
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = 4;
  localparam bit          HAS_WAIT = (WAIT_CYCLES != 0);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;

  logic        wb_en_q;
  logic        mem_r_en_q;
  logic [31:0] alu_res_q;
  logic [31:0] mem_read_q;
  logic [4:0]  dest_q;
  logic        addr_err_q;

  logic [31:0] mem [DEPTH];

  logic [31:0]   off;
  logic          valid;
  logic [AW-1:0] idx;
  logic          memop;
  logic          complete;

  // Address decode relative to the RAM window; subtraction wraps so addresses
  // below BASE_ADDR land far out of range.
  assign off   = ALUResIn - 32'(BASE_ADDR);
  assign valid = (off < 32'(DEPTH * 4)) && (off[1:0] == 2'b00);
  assign idx   = off[AW+1:2];
  assign memop = MEM_R_EN_IN | MEM_W_EN_IN;

  assign complete = ((state_q == S_IDLE) && memop && !HAS_WAIT) ||
                    ((state_q == S_WAIT) && (cnt_q == '0));

  assign freeze = ((state_q == S_IDLE) && memop && HAS_WAIT) ||
                  ((state_q == S_WAIT) && (cnt_q != '0));

  // Wait-state FSM and MEM->WB register; frozen cycles emit a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_read_q <= '0;
      dest_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (memop && HAS_WAIT) begin
            state_q <= S_WAIT;
            cnt_q   <= CW'(WAIT_CYCLES - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          else             state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (complete) begin
        wb_en_q    <= WB_EN_IN;
        mem_r_en_q <= MEM_R_EN_IN;
        alu_res_q  <= ALUResIn;
        mem_read_q <= valid ? mem[idx] : 32'd0;
        dest_q     <= destIn;
        addr_err_q <= !valid;
      end else if (freeze) begin
        wb_en_q    <= 1'b0;
        mem_r_en_q <= 1'b0;
        addr_err_q <= 1'b0;
      end else begin
        wb_en_q    <= WB_EN_IN;
        mem_r_en_q <= MEM_R_EN_IN;
        alu_res_q  <= ALUResIn;
        dest_q     <= destIn;
        addr_err_q <= 1'b0;
      end
    end
  end

  // Data RAM, not reset; a combined load+store reads the pre-store word above.
  always_ff @(posedge clk) begin
    if (complete && MEM_W_EN_IN && valid) mem[idx] <= STValIn;
  end

  assign WB_EN    = wb_en_q;
  assign MEM_R_EN = mem_r_en_q;
  assign ALURes   = alu_res_q;
  assign memRead  = mem_read_q;
  assign dest     = dest_q;
  assign addrErr  = addr_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a 2-wait-state instance and a zero-wait instance.
module tb_mem_stage;

  logic clk;
  logic rst;

  logic        a_wb, a_rd, a_wr;
  logic [31:0] a_alu, a_st;
  logic [4:0]  a_dest_i;
  logic        a_freeze, a_WB_EN, a_MEM_R_EN, a_addrErr;
  logic [31:0] a_ALURes, a_memRead;
  logic [4:0]  a_dest;

  logic        b_wb, b_rd, b_wr;
  logic [31:0] b_alu, b_st;
  logic [4:0]  b_dest_i;
  logic        b_freeze, b_WB_EN, b_MEM_R_EN, b_addrErr;
  logic [31:0] b_ALURes, b_memRead;
  logic [4:0]  b_dest;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.DEPTH(256), .BASE_ADDR(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .WB_EN_IN(a_wb), .MEM_R_EN_IN(a_rd), .MEM_W_EN_IN(a_wr),
    .ALUResIn(a_alu), .STValIn(a_st), .destIn(a_dest_i),
    .freeze(a_freeze), .WB_EN(a_WB_EN), .MEM_R_EN(a_MEM_R_EN),
    .ALURes(a_ALURes), .memRead(a_memRead), .dest(a_dest), .addrErr(a_addrErr)
  );

  mem_stage #(.DEPTH(256), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .WB_EN_IN(b_wb), .MEM_R_EN_IN(b_rd), .MEM_W_EN_IN(b_wr),
    .ALUResIn(b_alu), .STValIn(b_st), .destIn(b_dest_i),
    .freeze(b_freeze), .WB_EN(b_WB_EN), .MEM_R_EN(b_MEM_R_EN),
    .ALURes(b_ALURes), .memRead(b_memRead), .dest(b_dest), .addrErr(b_addrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_a();
    a_wb = 1'b0; a_rd = 1'b0; a_wr = 1'b0;
    a_alu = 32'd0; a_st = 32'd0; a_dest_i = 5'd0;
  endtask

  // One memory op on the 2-wait instance: freeze high 2 cycles, bubbles while
  // frozen, outputs visible on return.
  task automatic op_a(input logic r, input logic w, input logic [31:0] addr,
                      input logic [31:0] data, input logic [4:0] d, input logic wb);
    a_rd = r; a_wr = w; a_alu = addr; a_st = data; a_dest_i = d; a_wb = wb;
    for (int i = 0; i <= 2; i++) begin
      #1;
      check("freeze_pattern", 32'(a_freeze), 32'(i < 2));
      if (i > 0) begin
        check("bubble_wb_en", 32'(a_WB_EN), 32'd0);
        check("bubble_mem_r_en", 32'(a_MEM_R_EN), 32'd0);
      end
      tick();
    end
    nop_a();
  endtask

  initial begin
    rst = 1'b0;
    nop_a();
    b_wb = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
    b_alu = 32'd0; b_st = 32'd0; b_dest_i = 5'd0;
    #3;
    check("reset_wb_en", 32'(a_WB_EN), 32'd0);
    check("reset_alu_res", a_ALURes, 32'd0);
    check("reset_mem_read", a_memRead, 32'd0);
    check("reset_dest", 32'(a_dest), 32'd0);
    check("reset_addr_err", 32'(a_addrErr), 32'd0);
    check("reset_freeze", 32'(a_freeze), 32'd0);
    #10 rst = 1'b1;
    tick();

    // Known value at 1024, then abort a store of DEADBEEF with reset
    op_a(1'b0, 1'b1, 32'd1024, 32'h1111_1111, 5'd0, 1'b0);
    op_a(1'b1, 1'b0, 32'd1024, 32'd0, 5'd5, 1'b1);
    check("preload_mem_read", a_memRead, 32'h1111_1111);
    check("preload_dest", 32'(a_dest), 32'd5);
    a_wr = 1'b1; a_alu = 32'd1024; a_st = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_wait_alu_res", a_ALURes, 32'd0);
    check("rst_mid_wait_mem_read", a_memRead, 32'd0);
    check("rst_mid_wait_dest", 32'(a_dest), 32'd0);
    check("rst_mid_wait_freeze", 32'(a_freeze), 32'd1);
    nop_a();
    #1;
    check("rst_idle_freeze", 32'(a_freeze), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    op_a(1'b1, 1'b0, 32'd1024, 32'd0, 5'd1, 1'b1);
    check("reload_after_abort", a_memRead, 32'h1111_1111);

    // Non-memory pass-through
    a_wb = 1'b1; a_alu = 32'h1234_5678; a_dest_i = 5'd7;
    #1;
    check("pass_freeze_before", 32'(a_freeze), 32'd0);
    tick();
    check("pass_wb_en", 32'(a_WB_EN), 32'd1);
    check("pass_alu_res", a_ALURes, 32'h1234_5678);
    check("pass_dest", 32'(a_dest), 32'd7);
    check("pass_mem_r_en", 32'(a_MEM_R_EN), 32'd0);
    check("pass_mem_read_hold", a_memRead, 32'h1111_1111);
    check("pass_freeze_after", 32'(a_freeze), 32'd0);
    nop_a();

    // Store then load with wait states
    op_a(1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D, 5'd0, 1'b0);
    check("store_wb_en", 32'(a_WB_EN), 32'd0);
    check("store_addr_err", 32'(a_addrErr), 32'd0);
    op_a(1'b1, 1'b0, 32'd1032, 32'd0, 5'd3, 1'b1);
    check("load_mem_read", a_memRead, 32'hCAFE_F00D);
    check("load_mem_r_en", 32'(a_MEM_R_EN), 32'd1);
    check("load_wb_en", 32'(a_WB_EN), 32'd1);
    check("load_dest", 32'(a_dest), 32'd3);
    check("load_alu_res", a_ALURes, 32'd1032);

    // Misaligned load
    op_a(1'b1, 1'b0, 32'd1026, 32'd0, 5'd2, 1'b1);
    check("misaligned_mem_read", a_memRead, 32'd0);
    check("misaligned_addr_err", 32'(a_addrErr), 32'd1);
    tick();
    check("misaligned_err_one_cycle", 32'(a_addrErr), 32'd0);

    // Below base address wraps out of range
    op_a(1'b1, 1'b0, 32'd1020, 32'd0, 5'd2, 1'b1);
    check("below_base_mem_read", a_memRead, 32'd0);
    check("below_base_addr_err", 32'(a_addrErr), 32'd1);

    // Fill every word, store just past the end, verify nothing changed
    for (int i = 0; i < 256; i++)
      op_a(1'b0, 1'b1, 32'(1024 + 4 * i), 32'h5A00_0000 | 32'(i), 5'd0, 1'b0);
    op_a(1'b0, 1'b1, 32'd2048, 32'hFFFF_FFFF, 5'd0, 1'b0);
    check("oob_store_addr_err", 32'(a_addrErr), 32'd1);
    for (int i = 0; i < 256; i++) begin
      op_a(1'b1, 1'b0, 32'(1024 + 4 * i), 32'd0, 5'd4, 1'b1);
      check($sformatf("readback_w%0d", i), a_memRead, 32'h5A00_0000 | 32'(i));
      if (i == 255) check("last_word_addr_err", 32'(a_addrErr), 32'd0);
    end

    // Combined load+store returns the pre-store word
    op_a(1'b0, 1'b1, 32'd1040, 32'h0000_0011, 5'd0, 1'b0);
    op_a(1'b1, 1'b1, 32'd1040, 32'h0000_0022, 5'd9, 1'b1);
    check("rw_same_mem_read", a_memRead, 32'h0000_0011);
    check("rw_same_dest", 32'(a_dest), 32'd9);
    op_a(1'b1, 1'b0, 32'd1040, 32'd0, 5'd9, 1'b1);
    check("rw_followup_load", a_memRead, 32'h0000_0022);

    // Zero-wait instance: alternating store/load every cycle
    for (int k = 0; k < 4; k++) begin
      b_rd = 1'b0; b_wr = 1'b1; b_wb = 1'b0;
      b_alu = 32'(1024 + 4 * k); b_st = 32'hB000_0000 + 32'(k); b_dest_i = 5'd0;
      #1;
      check("w0_store_freeze", 32'(b_freeze), 32'd0);
      tick();
      check("w0_store_addr_err", 32'(b_addrErr), 32'd0);
      b_rd = 1'b1; b_wr = 1'b0; b_wb = 1'b1; b_dest_i = 5'(10 + k);
      #1;
      check("w0_load_freeze", 32'(b_freeze), 32'd0);
      tick();
      check("w0_load_mem_read", b_memRead, 32'hB000_0000 + 32'(k));
      check("w0_load_mem_r_en", 32'(b_MEM_R_EN), 32'd1);
      check("w0_load_dest", 32'(b_dest), 32'(10 + k));
    end
    b_rd = 1'b0; b_wr = 1'b0; b_wb = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
